// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC ISA constants and the D->E pipeline register layout.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [31:0] NOP_INSN = 32'h6800_0000;
    localparam logic [3:0]  RA_IDX   = 4'd15;

    localparam int OPCODE_LSB  = 27;
    localparam int IBIT_POS    = 26;
    localparam int RD_LSB      = 22;
    localparam int RS1_LSB     = 18;
    localparam int RS2_LSB     = 14;
    localparam int IMM_MOD_LSB = 16;

    localparam logic [1:0] IMM_MOD_SEXT = 2'b00;
    localparam logic [1:0] IMM_MOD_ZEXT = 2'b01;
    localparam logic [1:0] IMM_MOD_HIGH = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] branchtarget;
        logic [3:0]  rd;
        logic [4:0]  opcode;
        logic        isimm;
        logic        isld;
        logic        isst;
        logic        isbeq;
        logic        isbgt;
        logic        isubranch;
        logic        iscall;
        logic        isret;
        logic        iswb;
    } de_reg_t;

    function automatic de_reg_t make_bubble();
        de_reg_t b;
        b        = '0;
        b.opcode = OP_NOP;
        return b;
    endfunction

    // Modifier 2'b11 is unassigned in the ISA and falls back to sign extension.
    function automatic logic [31:0] extend_imm(input logic [17:0] mod_imm);
        logic [31:0] r;
        case (mod_imm[IMM_MOD_LSB +: 2])
            IMM_MOD_ZEXT: r = {16'd0, mod_imm[15:0]};
            IMM_MOD_HIGH: r = {mod_imm[15:0], 16'd0};
            default:      r = {{16{mod_imm[15]}}, mod_imm[15:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/register_file.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port.
// DECODE_RF_BYPASS_EN makes a same-cycle write visible on the read ports.
module register_file
    import simplerisc_pkg::*;
(
    input  logic        clk,
    input  logic [3:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [3:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [16];

    always_ff @(posedge clk) begin
        if (we) begin
            regs_q[waddr] <= wdata;
        end
    end

`ifdef DECODE_RF_BYPASS_EN
    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_q[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_q[raddr_b];
`else
    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
`endif

endmodule

// File: rtl/decode_cycle.sv
// SimpleRISC decode stage: field decode, RF read, control generation and load-use stall with replay.
// Optional macro DECODE_RF_BYPASS_EN: write-through RF; otherwise writeback conflicts also stall.
module decode_cycle
    import simplerisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_D,
    input  logic [31:0] pc_D,
    input  logic        isbranchtaken_E,
    input  logic        interrupt,
    input  logic        regwrite_W,
    input  logic [3:0]  rd_W,
    input  logic [31:0] result_W,
    output logic        add_stall,
    output logic [31:0] pc_E,
    output logic [31:0] op1_E,
    output logic [31:0] op2_E,
    output logic [31:0] imm_E,
    output logic [31:0] branchtarget_E,
    output logic [3:0]  rd_E,
    output logic [4:0]  opcode_E,
    output logic        isimm_E,
    output logic        isld_E,
    output logic        isst_E,
    output logic        isbeq_E,
    output logic        isbgt_E,
    output logic        isubranch_E,
    output logic        iscall_E,
    output logic        isret_E,
    output logic        iswb_E
);

    de_reg_t     de_q, de_d, dec;
    logic [31:0] hold_insn_q, hold_insn_d, hold_pc_q, hold_pc_d;
    logic        replay_v_q, replay_v_d;

    logic [31:0] insn, pc, imm, rs1_data, rs2_data;
    logic [4:0]  opcode;
    logic        i_bit, uses_rs1, uses_rs2, load_use, wb_hazard, flush, stall;
    logic [3:0]  rd_field, rs1_addr, rs2_addr;

    assign insn     = replay_v_q ? hold_insn_q : instruction_D;
    assign pc       = replay_v_q ? hold_pc_q : pc_D;
    assign opcode   = insn[OPCODE_LSB +: 5];
    assign i_bit    = insn[IBIT_POS];
    assign rd_field = insn[RD_LSB +: 4];
    assign rs1_addr = (opcode == OP_RET) ? RA_IDX : insn[RS1_LSB +: 4];
    assign rs2_addr = (opcode == OP_ST) ? rd_field : insn[RS2_LSB +: 4];
    assign imm      = extend_imm(insn[17:0]);

    register_file u_rf (
        .clk     (clk),
        .raddr_a (rs1_addr),
        .rdata_a (rs1_data),
        .raddr_b (rs2_addr),
        .rdata_b (rs2_data),
        .we      (regwrite_W),
        .waddr   (rd_W),
        .wdata   (result_W)
    );

    always_comb begin
        uses_rs1 = !(opcode inside {OP_NOP, OP_MOV, OP_NOT, OP_B, OP_BEQ, OP_BGT, OP_CALL});
        uses_rs2 = (opcode == OP_ST) || (!i_bit && (opcode <= OP_ASR));

        dec              = make_bubble();
        dec.pc           = pc;
        dec.op1          = rs1_data;
        dec.op2          = (i_bit && (opcode != OP_ST)) ? imm : rs2_data;
        dec.imm          = imm;
        dec.branchtarget = pc + {{3{insn[26]}}, insn[26:0], 2'b00};
        dec.rd           = (opcode == OP_CALL) ? RA_IDX : rd_field;
        dec.opcode       = opcode;
        dec.isimm        = i_bit;
        dec.isld         = (opcode == OP_LD);
        dec.isst         = (opcode == OP_ST);
        dec.isbeq        = (opcode == OP_BEQ);
        dec.isbgt        = (opcode == OP_BGT);
        dec.isubranch    = opcode inside {OP_B, OP_CALL, OP_RET};
        dec.iscall       = (opcode == OP_CALL);
        dec.isret        = (opcode == OP_RET);
        dec.iswb         = (opcode <= OP_ASR) || (opcode == OP_LD) || (opcode == OP_CALL);
    end

    assign load_use = de_q.isld && de_q.iswb &&
                      ((uses_rs1 && (rs1_addr == de_q.rd)) || (uses_rs2 && (rs2_addr == de_q.rd)));

`ifdef DECODE_RF_BYPASS_EN
    assign wb_hazard = 1'b0;
`else
    assign wb_hazard = regwrite_W &&
                       ((uses_rs1 && (rs1_addr == rd_W)) || (uses_rs2 && (rs2_addr == rd_W)));
`endif

    assign flush     = isbranchtaken_E || interrupt;
    assign stall     = !rst && !flush && (load_use || wb_hazard);
    assign add_stall = stall;

    // A stall re-captures the instruction being decoded, so back-to-back stalls during replay keep it held.
    always_comb begin
        de_d        = dec;
        hold_insn_d = hold_insn_q;
        hold_pc_d   = hold_pc_q;
        replay_v_d  = 1'b0;
        if (flush) begin
            de_d        = make_bubble();
            hold_insn_d = NOP_INSN;
            hold_pc_d   = '0;
        end else if (stall) begin
            de_d        = make_bubble();
            hold_insn_d = insn;
            hold_pc_d   = pc;
            replay_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q        <= make_bubble();
            hold_insn_q <= NOP_INSN;
            hold_pc_q   <= '0;
            replay_v_q  <= 1'b0;
        end else begin
            de_q        <= de_d;
            hold_insn_q <= hold_insn_d;
            hold_pc_q   <= hold_pc_d;
            replay_v_q  <= replay_v_d;
        end
    end

    assign pc_E           = de_q.pc;
    assign op1_E          = de_q.op1;
    assign op2_E          = de_q.op2;
    assign imm_E          = de_q.imm;
    assign branchtarget_E = de_q.branchtarget;
    assign rd_E           = de_q.rd;
    assign opcode_E       = de_q.opcode;
    assign isimm_E        = de_q.isimm;
    assign isld_E         = de_q.isld;
    assign isst_E         = de_q.isst;
    assign isbeq_E        = de_q.isbeq;
    assign isbgt_E        = de_q.isbgt;
    assign isubranch_E    = de_q.isubranch;
    assign iscall_E       = de_q.iscall;
    assign isret_E        = de_q.isret;
    assign iswb_E         = de_q.iswb;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: decode vector table plus stall, replay, flush, reset and writeback sequences.
module tb_decode_cycle;
    import simplerisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_D, pc_D, result_W;
    logic        isbranchtaken_E, interrupt, regwrite_W;
    logic [3:0]  rd_W;
    logic        add_stall;
    logic [31:0] pc_E, op1_E, op2_E, imm_E, branchtarget_E;
    logic [3:0]  rd_E;
    logic [4:0]  opcode_E;
    logic        isimm_E, isld_E, isst_E, isbeq_E, isbgt_E, isubranch_E, iscall_E, isret_E, iswb_E;

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] C_IMM  = 9'h100;
    localparam logic [8:0] C_LD   = 9'h080;
    localparam logic [8:0] C_ST   = 9'h040;
    localparam logic [8:0] C_BEQ  = 9'h020;
    localparam logic [8:0] C_BGT  = 9'h010;
    localparam logic [8:0] C_UB   = 9'h008;
    localparam logic [8:0] C_CALL = 9'h004;
    localparam logic [8:0] C_RET  = 9'h002;
    localparam logic [8:0] C_WB   = 9'h001;

    typedef struct {
        string        name;
        logic [31:0]  insn;
        logic [31:0]  pc;
        logic [177:0] exp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk             (clk),
        .rst             (rst),
        .instruction_D   (instruction_D),
        .pc_D            (pc_D),
        .isbranchtaken_E (isbranchtaken_E),
        .interrupt       (interrupt),
        .regwrite_W      (regwrite_W),
        .rd_W            (rd_W),
        .result_W        (result_W),
        .add_stall       (add_stall),
        .pc_E            (pc_E),
        .op1_E           (op1_E),
        .op2_E           (op2_E),
        .imm_E           (imm_E),
        .branchtarget_E  (branchtarget_E),
        .rd_E            (rd_E),
        .opcode_E        (opcode_E),
        .isimm_E         (isimm_E),
        .isld_E          (isld_E),
        .isst_E          (isst_E),
        .isbeq_E         (isbeq_E),
        .isbgt_E         (isbgt_E),
        .isubranch_E     (isubranch_E),
        .iscall_E        (iscall_E),
        .isret_E         (isret_E),
        .iswb_E          (iswb_E)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                          input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                                          input logic [1:0] md, input logic [15:0] im);
        return {op, 1'b1, rd, rs1, md, im};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] op, input logic [26:0] off);
        return {op, off};
    endfunction

    function automatic logic [31:0] bt_of(input logic [31:0] pc, input logic [31:0] insn);
        return pc + {{3{insn[26]}}, insn[26:0], 2'b00};
    endfunction

    function automatic logic [177:0] pk(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                                        input logic [31:0] imm, input logic [31:0] bt, input logic [3:0] rd,
                                        input logic [4:0] opc, input logic [8:0] ctrl);
        return {pc, op1, op2, imm, bt, rd, opc, ctrl};
    endfunction

    function automatic logic [177:0] e_now();
        return {pc_E, op1_E, op2_E, imm_E, branchtarget_E, rd_E, opcode_E,
                isimm_E, isld_E, isst_E, isbeq_E, isbgt_E, isubranch_E, iscall_E, isret_E, iswb_E};
    endfunction

    task automatic compare(input string name, input logic [177:0] act, input logic [177:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] insn, input logic [31:0] pc);
        @(negedge clk);
        instruction_D = insn;
        pc_D          = pc;
        #1;
    endtask

    task automatic checkStall(input string name, input logic exp);
        compare(name, {177'd0, add_stall}, {177'd0, exp});
    endtask

    task automatic checkOutput(input string name, input logic [177:0] exp);
        @(posedge clk);
        #1;
        compare(name, e_now(), exp);
    endtask

    logic [31:0]  ld_r3, add_r4, sub_r1, sub_r9, mov_r7, add_imm, st_r3;
    logic [177:0] bub;

    initial begin
        rst             = 1'b1;
        instruction_D   = NOP_INSN;
        pc_D            = '0;
        isbranchtaken_E = 1'b0;
        interrupt       = 1'b0;
        regwrite_W      = 1'b0;
        rd_W            = '0;
        result_W        = '0;

        ld_r3   = enc_i(OP_LD, 4'd3, 4'd1, 2'b00, 16'h0000);
        add_r4  = enc_r(OP_ADD, 4'd4, 4'd3, 4'd5);
        sub_r1  = enc_r(OP_SUB, 4'd1, 4'd2, 4'd6);
        sub_r9  = enc_r(OP_SUB, 4'd9, 4'd2, 4'd6);
        mov_r7  = enc_i(OP_MOV, 4'd7, 4'd0, 2'b00, 16'h0005);
        add_imm = enc_i(OP_ADD, 4'd4, 4'd1, 2'b00, 16'hC000);
        st_r3   = enc_i(OP_ST, 4'd3, 4'd1, 2'b00, 16'h0008);
        bub     = pk(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, OP_NOP, 9'h0);

        // Register r<i> holds 32'h1100 + i throughout the decode table.
        vecs[0]  = '{"add_imm_sext", enc_i(OP_ADD, 4'd1, 4'd2, 2'b00, 16'hFFFC), 32'h10, '0};
        vecs[1]  = '{"add_imm_high", enc_i(OP_ADD, 4'd1, 4'd2, 2'b10, 16'h1234), 32'h14, '0};
        vecs[2]  = '{"or_imm_zext",  enc_i(OP_OR,  4'd5, 4'd6, 2'b01, 16'h8001), 32'h18, '0};
        vecs[3]  = '{"and_imm_mod3", enc_i(OP_AND, 4'd5, 4'd6, 2'b11, 16'h8001), 32'h1C, '0};
        vecs[4]  = '{"sub_reg",      enc_r(OP_SUB, 4'd1, 4'd2, 4'd6),            32'h20, '0};
        vecs[5]  = '{"b_back1",      enc_b(OP_B, 27'h7FFFFFF),                   32'h100, '0};
        vecs[6]  = '{"st_imm",       st_r3,                                      32'h24, '0};
        vecs[7]  = '{"call_fwd",     enc_b(OP_CALL, 27'd4),                      32'h200, '0};
        vecs[8]  = '{"beq_back2",    enc_b(OP_BEQ, 27'h7FFFFFE),                 32'h40, '0};
        vecs[9]  = '{"ld_r3",        ld_r3,                                      32'h28, '0};
        vecs[10] = '{"nop_after_ld", NOP_INSN,                                   32'h2C, '0};
        vecs[11] = '{"mov_imm",      mov_r7,                                     32'h30, '0};
        vecs[12] = '{"bgt_fwd",      enc_b(OP_BGT, 27'h10),                      32'h44, '0};
        vecs[13] = '{"ret",          enc_b(OP_RET, 27'd0),                       32'h48, '0};

        vecs[0].exp  = pk(32'h10, 32'h1102, 32'hFFFF_FFFC, 32'hFFFF_FFFC, bt_of(32'h10, vecs[0].insn),
                          4'd1, OP_ADD, C_IMM | C_WB);
        vecs[1].exp  = pk(32'h14, 32'h1102, 32'h1234_0000, 32'h1234_0000, bt_of(32'h14, vecs[1].insn),
                          4'd1, OP_ADD, C_IMM | C_WB);
        vecs[2].exp  = pk(32'h18, 32'h1106, 32'h0000_8001, 32'h0000_8001, bt_of(32'h18, vecs[2].insn),
                          4'd5, OP_OR, C_IMM | C_WB);
        vecs[3].exp  = pk(32'h1C, 32'h1106, 32'hFFFF_8001, 32'hFFFF_8001, bt_of(32'h1C, vecs[3].insn),
                          4'd5, OP_AND, C_IMM | C_WB);
        vecs[4].exp  = pk(32'h20, 32'h1102, 32'h1106, 32'h0000_8000, bt_of(32'h20, vecs[4].insn),
                          4'd1, OP_SUB, C_WB);
        vecs[5].exp  = pk(32'h100, 32'h110F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FC,
                          4'd15, OP_B, C_IMM | C_UB);
        vecs[6].exp  = pk(32'h24, 32'h1101, 32'h1103, 32'h8, bt_of(32'h24, st_r3),
                          4'd3, OP_ST, C_IMM | C_ST);
        vecs[7].exp  = pk(32'h200, 32'h1100, 32'h1100, 32'h4, 32'h210,
                          4'd15, OP_CALL, C_CALL | C_UB | C_WB);
        vecs[8].exp  = pk(32'h40, 32'h110F, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h38,
                          4'd15, OP_BEQ, C_IMM | C_BEQ);
        vecs[9].exp  = pk(32'h28, 32'h1101, 32'h0, 32'h0, bt_of(32'h28, ld_r3),
                          4'd3, OP_LD, C_IMM | C_LD | C_WB);
        vecs[10].exp = pk(32'h2C, 32'h1100, 32'h1100, 32'h0, 32'h2C, 4'd0, OP_NOP, 9'h0);
        vecs[11].exp = pk(32'h30, 32'h1100, 32'h5, 32'h5, bt_of(32'h30, mov_r7),
                          4'd7, OP_MOV, C_IMM | C_WB);
        vecs[12].exp = pk(32'h44, 32'h1100, 32'h1100, 32'h10, 32'h84, 4'd0, OP_BGT, C_BGT);
        vecs[13].exp = pk(32'h48, 32'h110F, 32'h1100, 32'h0, 32'h48, 4'd0, OP_RET, C_RET | C_UB);

        repeat (2) @(posedge clk);
        #1;
        compare("reset_e_reg", e_now(), bub);
        checkStall("reset_stall", 1'b0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            regwrite_W = 1'b1;
            rd_W       = i[3:0];
            result_W   = 32'h1100 + i;
        end
        @(negedge clk);
        regwrite_W = 1'b0;
        rst        = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].insn, vecs[i].pc);
            checkStall({vecs[i].name, "_stall"}, 1'b0);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Load-use: one stall, one bubble, then the held add; instruction_D during replay is ignored.
        applyStimulus(ld_r3, 32'h300);
        checkOutput("lu_ld", pk(32'h300, 32'h1101, 32'h0, 32'h0, bt_of(32'h300, ld_r3), 4'd3, OP_LD,
                                C_IMM | C_LD | C_WB));
        applyStimulus(add_r4, 32'h304);
        checkStall("lu_stall", 1'b1);
        checkOutput("lu_bubble", bub);
        applyStimulus(sub_r9, 32'h308);
        checkStall("lu_replay_nostall", 1'b0);
        checkOutput("lu_add", pk(32'h304, 32'h1103, 32'h1105, 32'h4000, bt_of(32'h304, add_r4), 4'd4, OP_ADD, C_WB));
        applyStimulus(sub_r9, 32'h308);
        checkOutput("lu_next", pk(32'h308, 32'h1102, 32'h1106, 32'h8000, bt_of(32'h308, sub_r9), 4'd9, OP_SUB, C_WB));

        // Flush during the replay cycle discards the held add.
        applyStimulus(ld_r3, 32'h400);
        @(posedge clk);
        applyStimulus(add_r4, 32'h404);
        checkStall("fl_stall", 1'b1);
        checkOutput("fl_bubble1", bub);
        applyStimulus(mov_r7, 32'h408);
        isbranchtaken_E = 1'b1;
        #1;
        checkStall("fl_replay_nostall", 1'b0);
        checkOutput("fl_bubble2", bub);
        isbranchtaken_E = 1'b0;
        applyStimulus(mov_r7, 32'h40C);
        checkOutput("fl_after", pk(32'h40C, 32'h1100, 32'h5, 32'h5, bt_of(32'h40C, mov_r7), 4'd7, OP_MOV, C_IMM | C_WB));

        // An interrupt suppresses a pending load-use stall.
        applyStimulus(ld_r3, 32'h410);
        @(posedge clk);
        applyStimulus(add_r4, 32'h414);
        interrupt = 1'b1;
        #1;
        checkStall("irq_nostall", 1'b0);
        checkOutput("irq_bubble", bub);
        interrupt = 1'b0;
        applyStimulus(NOP_INSN, 32'h418);
        checkOutput("irq_after", pk(32'h418, 32'h1100, 32'h1100, 32'h0, 32'h418, 4'd0, OP_NOP, 9'h0));

        // Same-cycle writeback to a source register.
        applyStimulus(sub_r1, 32'h500);
        regwrite_W = 1'b1;
        rd_W       = 4'd2;
        result_W   = 32'h0000_DEAD;
        #1;
`ifdef DECODE_RF_BYPASS_EN
        checkStall("wb_stall", 1'b0);
`else
        checkStall("wb_stall", 1'b1);
        checkOutput("wb_bubble", bub);
        regwrite_W = 1'b0;
        applyStimulus(NOP_INSN, 32'h504);
        checkStall("wb_replay_nostall", 1'b0);
`endif
        checkOutput("wb_sub", pk(32'h500, 32'h0000_DEAD, 32'h1106, 32'h8000, bt_of(32'h500, sub_r1), 4'd1, OP_SUB, C_WB));
        regwrite_W = 1'b0;

        // Reset in the replay cycle drops the held instruction.
        applyStimulus(ld_r3, 32'h600);
        @(posedge clk);
        applyStimulus(add_r4, 32'h604);
        checkStall("rr_stall", 1'b1);
        checkOutput("rr_bubble", bub);
        applyStimulus(NOP_INSN, 32'h608);
        rst = 1'b1;
        checkOutput("rr_reset", bub);
        rst = 1'b0;
        applyStimulus(NOP_INSN, 32'h60C);
        checkOutput("rr_after", pk(32'h60C, 32'h1100, 32'h1100, 32'h0, 32'h60C, 4'd0, OP_NOP, 9'h0));

        // add_stall is held low while rst is asserted even with a live hazard.
        applyStimulus(ld_r3, 32'h610);
        @(posedge clk);
        applyStimulus(add_r4, 32'h614);
        rst = 1'b1;
        #1;
        checkStall("rst_nostall", 1'b0);
        checkOutput("rst_state", bub);
        rst = 1'b0;

        // rs2 field matches the load but I=1 makes it unused; st reads its rd as a source.
        applyStimulus(ld_r3, 32'h700);
        @(posedge clk);
        applyStimulus(add_imm, 32'h704);
        checkStall("imm_nostall", 1'b0);
        checkOutput("imm_add", pk(32'h704, 32'h1101, 32'hFFFF_C000, 32'hFFFF_C000, bt_of(32'h704, add_imm),
                                  4'd4, OP_ADD, C_IMM | C_WB));
        applyStimulus(ld_r3, 32'h708);
        @(posedge clk);
        applyStimulus(st_r3, 32'h70C);
        checkStall("st_stall", 1'b1);
        checkOutput("st_bubble", bub);
        checkOutput("st_replay", pk(32'h70C, 32'h1101, 32'h1103, 32'h8, bt_of(32'h70C, st_r3), 4'd3, OP_ST,
                                    C_IMM | C_ST));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
